// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Central stall sequencer for the 5-stage pipeline. It merges the ID
//   load-use bubble request and the EX multi-cycle divide request into one
//   6-bit stall vector for PC/IF/ID/EX/MEM/WB. It also runs a two-state FSM
//   that tracks an outstanding divide, a watchdog that forces a release when
//   the divider hangs, and a one-cycle divider start pulse.
//
//   Optional feature macro: STALL_PERF_EN
//     When defined, two saturating 32-bit performance counters record
//     load-use and divide stall cycles. When it is not defined, both counter
//     ports are tied to zero.
//
// Ports
//   clk               in   1   clock, single domain
//   rst               in   1   reset, asynchronous, active-high
//   stallreq_from_id  in   1   load-use hazard (lw in EX, dependent in ID)
//   stallreq_from_ex  in   1   EX holds a divide that needs multi-cycle exec
//   div_ready_i       in   1   divider result valid this cycle
//   stall             out  6   bit0 PC .. bit5 WB, 1 = stop
//   div_start_o       out  1   one-cycle pulse that launches the divider
//   div_busy_o        out  1   FSM is in DIV_BUSY
//   div_timeout_o     out  1   sticky, watchdog expired since reset
//   lu_stall_cnt_o    out  32  load-use stall cycles (STALL_PERF_EN)
//   div_stall_cnt_o   out  32  divide stall cycles (STALL_PERF_EN)
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
   parameter int DIV_MAX_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        div_ready_i,
   output logic [5:0]  stall,
   output logic        div_start_o,
   output logic        div_busy_o,
   output logic        div_timeout_o,
   output logic [31:0] lu_stall_cnt_o,
   output logic [31:0] div_stall_cnt_o
);

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_LU   = 6'b000111;  // PC/IF/ID hold, bubble into EX
   localparam logic [5:0] STALL_DIV  = 6'b001111;  // PC..EX hold, bubble into MEM

   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(DIV_MAX_CYCLES - 1);

   // A one-bit encoding leaves no unused codes, so every value decodes legally.
   typedef enum logic {
      RUN      = 1'b0,
      DIV_BUSY = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wdog;
   logic             armed;      // low during reset and until the first edge after it
   logic             wdog_hit;

   // Stall vector and start pulse respond in the same cycle as the request.
   // Requests are masked until the first clock edge after reset, which keeps
   // stall at zero while rst is high and on the first cycle after release.
   always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // path through the case statement can leave one unassigned (latch).
      stall       = STALL_NONE;
      div_start_o = 1'b0;
      wdog_hit    = 1'b0;
      case (state)
         DIV_BUSY: begin
            if (div_ready_i) begin
               stall = STALL_NONE;         // EX captures the result this edge
            end else if (wdog == WDOG_LAST) begin
               wdog_hit = 1'b1;
            end else begin
               stall = STALL_DIV;          // also covers any ID request
            end
         end
         default: begin
            if (!armed) begin
               stall = STALL_NONE;
            end else if (stallreq_from_ex) begin
               // EX wins a collision: its instruction is the older one.
               stall       = STALL_DIV;
               div_start_o = 1'b1;
            end else if (stallreq_from_id) begin
               stall = STALL_LU;
            end
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the values from before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RUN;
         wdog          <= '0;
         div_timeout_o <= 1'b0;
         armed         <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            DIV_BUSY: begin
               if (div_ready_i) begin
                  state <= RUN;
               end else if (wdog_hit) begin
                  state         <= RUN;
                  div_timeout_o <= 1'b1;
               end else begin
                  wdog <= wdog + CNT_W'(1);
               end
            end
            default: begin
               // A request seen in the release cycle is only taken once back in RUN.
               if (div_start_o) begin
                  state <= DIV_BUSY;
                  wdog  <= '0;
               end
            end
         endcase
      end
   end

   assign div_busy_o = (state == DIV_BUSY);

`ifdef STALL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_stall_cnt_o  <= '0;
         div_stall_cnt_o <= '0;
      end else begin
         if (stall == STALL_LU && lu_stall_cnt_o != 32'hFFFF_FFFF)
            lu_stall_cnt_o <= lu_stall_cnt_o + 32'd1;
         if (stall == STALL_DIV && div_stall_cnt_o != 32'hFFFF_FFFF)
            div_stall_cnt_o <= div_stall_cnt_o + 32'd1;
      end
   end
`else
   assign lu_stall_cnt_o  = 32'h0;
   assign div_stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//   Self-checking bench for pipe_stall_ctrl. A table of single-cycle vectors
//   exercises the main stall decisions, followed by hand-written sequences for
//   the 33-cycle divide, async reset mid-divide and the watchdog. Expected
//   values are pushed to a queue when stimulus is driven and popped when the
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_LU   = 6'b000111;
   localparam logic [5:0] S_DIV  = 6'b001111;

   typedef struct {
      logic       id;
      logic       ex;
      logic       rdy;
      logic [5:0] exp_stall;
      logic       exp_start;
      logic       exp_busy;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq_from_id = 1'b0;
   logic        stallreq_from_ex = 1'b0;
   logic        div_ready_i = 1'b0;
   logic [5:0]  stall;
   logic        div_start_o;
   logic        div_busy_o;
   logic        div_timeout_o;
   logic [31:0] lu_stall_cnt_o;
   logic [31:0] div_stall_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t sb_q[$];

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.DIV_MAX_CYCLES(40), .CNT_W(6)) dut (
      .clk              (clk),
      .rst              (rst),
      .stallreq_from_id (stallreq_from_id),
      .stallreq_from_ex (stallreq_from_ex),
      .div_ready_i      (div_ready_i),
      .stall            (stall),
      .div_start_o      (div_start_o),
      .div_busy_o       (div_busy_o),
      .div_timeout_o    (div_timeout_o),
      .lu_stall_cnt_o   (lu_stall_cnt_o),
      .div_stall_cnt_o  (div_stall_cnt_o)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, record the expectation, compare at negedge,
   // then advance to just after the next rising edge.
   task automatic step(input logic id, input logic ex, input logic rdy,
                       input logic [5:0] es, input logic est, input logic eb,
                       input string nm);
      vec_t v;
      vec_t got;
      v = '{id, ex, rdy, es, est, eb};
      stallreq_from_id = id;
      stallreq_from_ex = ex;
      div_ready_i      = rdy;
      sb_q.push_back(v);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         check({nm, " sb_empty"}, 32'd1, 32'd0);
      end else begin
         got = sb_q.pop_front();
         check({nm, " stall"}, {26'd0, stall}, {26'd0, got.exp_stall});
         check({nm, " start"}, {31'd0, div_start_o}, {31'd0, got.exp_start});
         check({nm, " busy"},  {31'd0, div_busy_o},  {31'd0, got.exp_busy});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input string nm, input int lu, input int dv);
`ifdef STALL_PERF_EN
      check({nm, " lu_cnt"},  lu_stall_cnt_o,  32'(lu));
      check({nm, " div_cnt"}, div_stall_cnt_o, 32'(dv));
`else
      check({nm, " lu_cnt"},  lu_stall_cnt_o,  32'h0);
      check({nm, " div_cnt"}, div_stall_cnt_o, 32'h0);
      if (lu < 0 || dv < 0) $display("negative count request %0d %0d", lu, dv);
`endif
   endtask

   task automatic release_reset();
      stallreq_from_id = 1'b0;
      stallreq_from_ex = 1'b0;
      div_ready_i      = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t tbl[10];
      tbl[0] = '{1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0};  // idle
      tbl[1] = '{1'b1, 1'b0, 1'b0, S_LU,   1'b0, 1'b0};  // load-use
      tbl[2] = '{1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0};  // LU lasts one cycle
      tbl[3] = '{1'b0, 1'b0, 1'b1, S_NONE, 1'b0, 1'b0};  // ready ignored in RUN
      tbl[4] = '{1'b1, 1'b1, 1'b0, S_DIV,  1'b1, 1'b0};  // collision, EX wins
      tbl[5] = '{1'b1, 1'b0, 1'b0, S_DIV,  1'b0, 1'b1};  // ID ignored while busy
      tbl[6] = '{1'b0, 1'b1, 1'b1, S_NONE, 1'b0, 1'b1};  // release, EX not taken
      tbl[7] = '{1'b0, 1'b1, 1'b0, S_DIV,  1'b1, 1'b0};  // EX taken next cycle
      tbl[8] = '{1'b0, 1'b0, 1'b1, S_NONE, 1'b0, 1'b1};  // one-busy-cycle divide
      tbl[9] = '{1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0};  // back to idle

      // Reset: outputs quiet even with a request pending while rst is high.
      stallreq_from_id = 1'b1;
      stallreq_from_ex = 1'b1;
      #13;
      check("rst stall",   {26'd0, stall}, 32'd0);
      check("rst start",   {31'd0, div_start_o}, 32'd0);
      check("rst busy",    {31'd0, div_busy_o}, 32'd0);
      check("rst timeout", {31'd0, div_timeout_o}, 32'd0);
      check_cnt("rst", 0, 0);
      release_reset();

      for (int i = 0; i < 10; i++)
         step(tbl[i].id, tbl[i].ex, tbl[i].rdy, tbl[i].exp_stall,
              tbl[i].exp_start, tbl[i].exp_busy, $sformatf("vec%0d", i));
      check_cnt("table", 1, 3);

      // Reset mid-divide at busy cycle 10.
      step(1'b0, 1'b1, 1'b0, S_DIV, 1'b1, 1'b0, "mid start");
      for (int i = 1; i < 10; i++)
         step(1'b0, 1'b0, 1'b0, S_DIV, 1'b0, 1'b1, "mid busy");
      #3;
      rst = 1'b1;
      #1;
      check("mid rst stall",   {26'd0, stall}, 32'd0);
      check("mid rst start",   {31'd0, div_start_o}, 32'd0);
      check("mid rst busy",    {31'd0, div_busy_o}, 32'd0);
      check("mid rst timeout", {31'd0, div_timeout_o}, 32'd0);
      check_cnt("mid rst", 0, 0);
      release_reset();

      // One load-use cycle, then a divide with ready on cycle 33.
      step(1'b1, 1'b0, 1'b0, S_LU, 1'b0, 1'b0, "lu");
      step(1'b0, 1'b1, 1'b0, S_DIV, 1'b1, 1'b0, "div33 start");
      for (int i = 1; i <= 32; i++)
         step(1'b0, 1'b0, 1'b0, S_DIV, 1'b0, 1'b1, $sformatf("div33 busy%0d", i));
      step(1'b0, 1'b0, 1'b1, S_NONE, 1'b0, 1'b1, "div33 ready");
      step(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, "div33 after");
      check_cnt("div33", 1, 33);
      check("div33 timeout", {31'd0, div_timeout_o}, 32'd0);

      // Watchdog: ready never arrives, forced release on busy cycle 40.
      step(1'b0, 1'b1, 1'b0, S_DIV, 1'b1, 1'b0, "wd start");
      for (int i = 1; i <= 39; i++)
         step(1'b0, 1'b0, 1'b0, S_DIV, 1'b0, 1'b1, $sformatf("wd busy%0d", i));
      check("wd timeout pre", {31'd0, div_timeout_o}, 32'd0);
      step(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b1, "wd release");
      check("wd timeout set", {31'd0, div_timeout_o}, 32'd1);
      step(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, "wd after");

      // Next divide still starts normally and the timeout flag stays set.
      step(1'b0, 1'b1, 1'b0, S_DIV, 1'b1, 1'b0, "post start");
      step(1'b0, 1'b0, 1'b1, S_NONE, 1'b0, 1'b1, "post ready");
      step(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, "post idle");
      check("post timeout sticky", {31'd0, div_timeout_o}, 32'd1);
      check_cnt("final", 1, 74);

      check("sb drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
